// File: rtl/ads7950_pkg.sv
// Shared types and field layout for the ADS7950 scan sequencer: FSM states,
// manual-mode command fields and the tagged FIFO sample word.
package ads7950_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_PUSH
  } state_e;

  localparam logic [3:0]  MODE_MANUAL   = 4'b0001;
  localparam logic        PROG_BIT      = 1'b1;
  localparam int unsigned CMD_MODE_LSB  = 12;
  localparam int unsigned CMD_PROG_BIT  = 11;
  localparam int unsigned CMD_CH_LSB    = 7;
  localparam int unsigned CMD_RANGE_BIT = 6;

  localparam int unsigned FW_SCAN_LSB   = 24;
  localparam int unsigned FW_TAG_LSB    = 16;
  localparam int unsigned FW_DATA_LSB   = 0;

  function automatic logic [15:0] make_cmd(input logic [3:0] ch, input logic rng);
    logic [15:0] w;
    w = '0;
    w[CMD_MODE_LSB +: 4] = MODE_MANUAL;
    w[CMD_PROG_BIT]      = PROG_BIT;
    w[CMD_CH_LSB +: 4]   = ch;
    w[CMD_RANGE_BIT]     = rng;
    return w;
  endfunction

  function automatic logic [31:0] make_word(input logic [7:0] scan, input logic [15:0] rx);
    logic [31:0] w;
    w = '0;
    w[FW_SCAN_LSB +: 8]  = scan;
    w[FW_TAG_LSB +: 4]   = rx[15:12];
    w[FW_DATA_LSB +: 12] = rx[11:0];
    return w;
  endfunction

endpackage

// File: rtl/ads7950_scan_sequencer_mask_next_channel.sv
// Finds the lowest set mask bit at or above 'from'; 'last' flags that no
// set bit lies above the channel found.
module mask_next_channel (
  input  logic [15:0] mask,
  input  logic [4:0]  from,
  output logic        found,
  output logic [3:0]  ch,
  output logic        last
);

  always_comb begin
    found = 1'b0;
    ch    = '0;
    // Scanning downward lets the lowest qualifying bit win.
    for (int unsigned i = 0; i < 16; i++) begin
      if (mask[15 - i] && (5'(15 - i) >= from)) begin
        found = 1'b1;
        ch    = 4'(15 - i);
      end
    end
    last = (((mask >> ch) >> 1) == 16'h0000);
  end

endmodule

// File: rtl/ads7950_scan_sequencer.sv
// Periodic ADS7950 scan scheduler: issues one manual-mode frame per enabled
// channel plus two pipeline-flush frames and pushes realigned tagged samples.
module ads7950_scan_sequencer
  import ads7950_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned SCAN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [15:0]       chan_mask,
  input  logic [CNT_W-1:0]  period,
  input  logic              range_2x,
  input  logic              clr_status,
  output logic              xfer_req,
  output logic [15:0]       xfer_tx,
  input  logic              xfer_ack,
  input  logic [15:0]       xfer_rx,
  output logic              fifo_wr,
  output logic [31:0]       fifo_din,
  input  logic              fifo_full,
  output logic              busy,
  output logic [SCAN_W-1:0] scan_count,
  output logic              overflow,
  output logic              overrun,
  output logic              tag_err
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d, limit;
  logic                tick;
  logic [15:0]         mask_q, mask_d;
  logic                range_q, range_d;
  logic [4:0]          k_q, k_d;
  logic [1:0]          dcnt_q, dcnt_d;
  logic [3:0]          tx_ch_q, tx_ch_d;
  logic                cur_last_q, cur_last_d;
  logic [3:0]          prev1_q, prev1_d, prev2_q, prev2_d;
  logic [15:0]         rx_q, rx_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic                overflow_q, overflow_d;
  logic                overrun_q, overrun_d;
  logic                tag_err_q, tag_err_d;
  logic                advance, ovf_set, tag_set;

  logic                first_found, first_last;
  logic [3:0]          first_ch;
  logic                nxt_found, nxt_last;
  logic [3:0]          nxt_ch;

  mask_next_channel u_first (
    .mask  (chan_mask),
    .from  (5'd0),
    .found (first_found),
    .ch    (first_ch),
    .last  (first_last)
  );

  mask_next_channel u_step (
    .mask  (mask_q),
    .from  ({1'b0, tx_ch_q} + 5'd1),
    .found (nxt_found),
    .ch    (nxt_ch),
    .last  (nxt_last)
  );

  always_comb begin
    limit = (period == '0) ? '0 : period - CNT_W'(1);
    tick  = enable && (timer_q == limit);
    if (!enable || tick) timer_d = '0;
    else                 timer_d = timer_q + CNT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    range_d    = range_q;
    k_d        = k_q;
    dcnt_d     = dcnt_q;
    tx_ch_d    = tx_ch_q;
    cur_last_d = cur_last_q;
    prev1_d    = prev1_q;
    prev2_d    = prev2_q;
    rx_d       = rx_q;
    scan_d     = scan_q;
    advance    = 1'b0;
    ovf_set    = 1'b0;
    tag_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick && first_found) begin
          mask_d     = chan_mask;
          range_d    = range_2x;
          k_d        = '0;
          dcnt_d     = '0;
          tx_ch_d    = first_ch;
          cur_last_d = first_last;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (xfer_ack) begin
          rx_d = xfer_rx;
          if (k_q < 5'd2) begin
            advance = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_PUSH;
          end
        end
      end
      ST_PUSH: begin
        tag_set = (rx_q[15:12] != prev2_q);
        ovf_set = fifo_full;
        if (dcnt_q == 2'd2) begin
          scan_d  = scan_q + SCAN_W'(1);
          state_d = ST_IDLE;
        end else begin
          advance = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // dcnt counts flush frames repeating the last real channel; the second one ends the scan.
    if (advance) begin
      k_d     = k_q + 5'd1;
      prev2_d = prev1_q;
      prev1_d = tx_ch_q;
      if (cur_last_q || (dcnt_q != 2'd0) || !nxt_found) begin
        dcnt_d = dcnt_q + 2'd1;
      end else begin
        tx_ch_d    = nxt_ch;
        cur_last_d = nxt_last;
      end
    end

    overflow_d = clr_status ? 1'b0 : overflow_q;
    overrun_d  = clr_status ? 1'b0 : overrun_q;
    tag_err_d  = clr_status ? 1'b0 : tag_err_q;
    if (ovf_set) overflow_d = 1'b1;
    if (tick && (state_q != ST_IDLE)) overrun_d = 1'b1;
    if (tag_set) tag_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      mask_q     <= '0;
      range_q    <= 1'b0;
      k_q        <= '0;
      dcnt_q     <= '0;
      tx_ch_q    <= '0;
      cur_last_q <= 1'b0;
      prev1_q    <= '0;
      prev2_q    <= '0;
      rx_q       <= '0;
      scan_q     <= '0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
      tag_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      mask_q     <= mask_d;
      range_q    <= range_d;
      k_q        <= k_d;
      dcnt_q     <= dcnt_d;
      tx_ch_q    <= tx_ch_d;
      cur_last_q <= cur_last_d;
      prev1_q    <= prev1_d;
      prev2_q    <= prev2_d;
      rx_q       <= rx_d;
      scan_q     <= scan_d;
      overflow_q <= overflow_d;
      overrun_q  <= overrun_d;
      tag_err_q  <= tag_err_d;
    end
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    xfer_req   = (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACK);
    xfer_tx    = xfer_req ? make_cmd(tx_ch_q, range_q) : '0;
    fifo_wr    = (state_q == ST_PUSH) && !fifo_full;
    fifo_din   = (state_q == ST_PUSH) ? make_word(8'(scan_q), rx_q) : '0;
    scan_count = scan_q;
    overflow   = overflow_q;
    overrun    = overrun_q;
    tag_err    = tag_err_q;
  end

endmodule

// File: tb/tb_ads7950_scan_sequencer.sv
// Directed bench for ads7950_scan_sequencer with an ADS7950/SPI responder
// that echoes the channel tag of the frame issued two frames earlier.
module tb_ads7950_scan_sequencer;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned SCAN_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [15:0]       chan_mask;
  logic [CNT_W-1:0]  period;
  logic              range_2x;
  logic              clr_status;
  logic              xfer_req;
  logic [15:0]       xfer_tx;
  logic              xfer_ack;
  logic [15:0]       xfer_rx;
  logic              fifo_wr;
  logic [31:0]       fifo_din;
  logic              fifo_full;
  logic              busy;
  logic [SCAN_W-1:0] scan_count;
  logic              overflow;
  logic              overrun;
  logic              tag_err;

  ads7950_scan_sequencer #(.CNT_W(CNT_W), .SCAN_W(SCAN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .chan_mask  (chan_mask),
    .period     (period),
    .range_2x   (range_2x),
    .clr_status (clr_status),
    .xfer_req   (xfer_req),
    .xfer_tx    (xfer_tx),
    .xfer_ack   (xfer_ack),
    .xfer_rx    (xfer_rx),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .scan_count (scan_count),
    .overflow   (overflow),
    .overrun    (overrun),
    .tag_err    (tag_err)
  );

  always #5 clk = ~clk;

  int          vec_n = 0;
  int          err_n = 0;
  int unsigned ack_dly = 2;
  int          frame_idx = 0;
  int          bad_frame = -1;
  int          full_frame = -1;
  logic [11:0] rx_data = 12'hABC;
  logic [15:0] tx_log [0:31];
  int          tx_n = 0;
  logic [31:0] fifo_log [0:31];
  int          fifo_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SPI master + ADC model: acks ack_dly cycles into a request, returns the
  // tag of the frame two acks back.
  initial begin
    int unsigned wait_cnt;
    int          full_cnt;
    logic [3:0]  hist1, hist2, tag;
    xfer_ack = 1'b0; xfer_rx = '0; fifo_full = 1'b0;
    wait_cnt = 0; full_cnt = 0; hist1 = '0; hist2 = '0;
    forever begin
      @(posedge clk); #1;
      xfer_ack = 1'b0;
      if (full_cnt > 0) begin fifo_full = 1'b1; full_cnt--; end
      else fifo_full = 1'b0;
      if (!rst) wait_cnt = 0;
      else if (xfer_req) begin
        if (wait_cnt >= ack_dly) begin
          tag = hist2;
          if (frame_idx == bad_frame) tag = tag ^ 4'h1;
          xfer_rx = {tag, rx_data};
          hist2 = hist1;
          hist1 = xfer_tx[10:7];
          if (tx_n < 32) tx_log[tx_n] = xfer_tx;
          tx_n++;
          if (frame_idx == full_frame) begin fifo_full = 1'b1; full_cnt = 1; end
          frame_idx++;
          xfer_ack = 1'b1;
          wait_cnt = 0;
        end else wait_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst && fifo_wr) begin
        if (fifo_n < 32) fifo_log[fifo_n] = fifo_din;
        fifo_n++;
      end
    end
  end

  task automatic start_scan(input logic [15:0] m, input logic [CNT_W-1:0] p, input logic r);
    @(negedge clk);
    chan_mask = m; period = p; range_2x = r;
    tx_n = 0; fifo_n = 0; frame_idx = 0;
    enable = 1'b1;
  endtask

  task automatic wait_count(input logic [SCAN_W-1:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (scan_count == target) break;
    end
    chk("scan_done", 32'(scan_count), 32'(target));
    enable = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (xfer_req) break;
    end
    chk("req_seen", 32'(xfer_req), 32'd1);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; chan_mask = '0; period = '0;
    range_2x = 1'b0; clr_status = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req",   32'(xfer_req),   32'd0);
    chk("rst_tx",    32'(xfer_tx),    32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_wr",    32'(fifo_wr),    32'd0);
    chk("rst_din",   fifo_din,        32'd0);
    chk("rst_count", 32'(scan_count), 32'd0);
    chk("rst_flags", {29'd0, overflow, overrun, tag_err}, 32'd0);
    rst = 1'b1;

    // two channels; mask/range changes mid-scan must not leak in
    start_scan(16'h0005, 100, 1'b0);
    wait_req(300);
    chk("t1_busy", 32'(busy), 32'd1);
    chan_mask = 16'hFFFF; range_2x = 1'b1;
    wait_count(8'd1, 2000);
    chk("t1_frames", tx_n, 32'd4);
    chk("t1_tx0", 32'(tx_log[0]), 32'h1800);
    chk("t1_tx1", 32'(tx_log[1]), 32'h1900);
    chk("t1_tx3", 32'(tx_log[3]), 32'h1900);
    chk("t1_words", fifo_n, 32'd2);
    chk("t1_w0", fifo_log[0], 32'h0000_0ABC);
    chk("t1_w1", fifo_log[1], 32'h0002_0ABC);
    chk("t1_flags", {29'd0, overflow, overrun, tag_err}, 32'd0);

    // single top channel, range bit set
    start_scan(16'h8000, 100, 1'b1);
    wait_count(8'd2, 2000);
    chk("t2_frames", tx_n, 32'd3);
    chk("t2_tx0", 32'(tx_log[0]), 32'h1FC0);
    chk("t2_words", fifo_n, 32'd1);
    chk("t2_w0", fifo_log[0], 32'h010F_0ABC);
    chk("t2_data", 32'(fifo_log[0][11:0]), 32'h0000_0ABC);

    // FIFO full on the second push
    full_frame = 3;
    start_scan(16'h0007, 100, 1'b0);
    wait_count(8'd3, 2000);
    full_frame = -1;
    chk("t3_frames", tx_n, 32'd5);
    chk("t3_words", fifo_n, 32'd2);
    chk("t3_w0", fifo_log[0], 32'h0200_0ABC);
    chk("t3_w1", fifo_log[1], 32'h0202_0ABC);
    chk("t3_ovf", 32'(overflow), 32'd1);
    pulse_clr();
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    chk("t3_ovr", 32'(overrun), 32'd0);

    // slow SPI with fast ticks
    ack_dly = 40;
    start_scan(16'h0003, 5, 1'b0);
    wait_count(8'd4, 3000);
    ack_dly = 2;
    chk("t4_ovr", 32'(overrun), 32'd1);
    chk("t4_frames", tx_n, 32'd4);
    chk("t4_tx3", 32'(tx_log[3]), 32'h1880);
    chk("t4_words", fifo_n, 32'd2);
    chk("t4_w0", fifo_log[0], 32'h0300_0ABC);
    chk("t4_w1", fifo_log[1], 32'h0301_0ABC);
    pulse_clr();
    chk("t4_clr", {29'd0, overflow, overrun, tag_err}, 32'd0);

    // corrupted tag on frame 3
    bad_frame = 3;
    start_scan(16'h0005, 100, 1'b0);
    wait_count(8'd5, 2000);
    bad_frame = -1;
    chk("t5_tagerr", 32'(tag_err), 32'd1);
    chk("t5_words", fifo_n, 32'd2);
    chk("t5_w0", fifo_log[0], 32'h0400_0ABC);
    chk("t5_w1", fifo_log[1], 32'h0403_0ABC);
    chk("t5_ovf", 32'(overflow), 32'd0);

    // async reset while waiting for an ack
    ack_dly = 40;
    start_scan(16'h0001, 3, 1'b0);
    wait_req(100);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_req",   32'(xfer_req),   32'd0);
    chk("t6_busy",  32'(busy),       32'd0);
    chk("t6_wr",    32'(fifo_wr),    32'd0);
    chk("t6_count", 32'(scan_count), 32'd0);
    chk("t6_flags", {29'd0, overflow, overrun, tag_err}, 32'd0);
    @(negedge clk);
    tx_n = 0; fifo_n = 0; frame_idx = 0;
    @(negedge clk);
    rst = 1'b1;
    wait_count(8'd1, 1000);
    ack_dly = 2;
    chk("t6_frames", tx_n, 32'd3);
    chk("t6_tx0", 32'(tx_log[0]), 32'h1800);
    chk("t6_words", fifo_n, 32'd1);
    chk("t6_w0", fifo_log[0], 32'h0000_0ABC);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
